writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage_if.sv | 35 +++
 rtl/writeback_stage.sv | 108 ++++++++++
 tb/tb_writeback_stage.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// M-to-W boundary bundle: M-stage inputs, stall/flush controls and W-stage outputs.
// The master side drives the M stage and controls; the slave side is the writeback stage.
interface writeback_stage_if #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
);
    logic             ValidM;
    logic             RegWriteM;
    logic [1:0]       ResultSrcM;
    logic [2:0]       Funct3M;
    logic [RA_W-1:0]  RdM;
    logic [XLEN-1:0]  ALU_ResultM;
    logic [XLEN-1:0]  ReadDataM;
    logic [XLEN-1:0]  PCPlus4M;
    logic             StallW;
    logic             FlushW;
    logic [XLEN-1:0]  ResultW;
    logic [RA_W-1:0]  RdW;
    logic             RegWriteW;
    logic             ValidW;
    logic [CNT_W-1:0] InstRetW;

    modport master (
        output ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALU_ResultM, ReadDataM, PCPlus4M, StallW, FlushW,
        input  ResultW, RdW, RegWriteW, ValidW, InstRetW
    );

    modport slave (
        input  ValidM, RegWriteM, ResultSrcM, Funct3M, RdM,
               ALU_ResultM, ReadDataM, PCPlus4M, StallW, FlushW,
        output ResultW, RdW, RegWriteW, ValidW, InstRetW
    );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: M->W register (1 cycle), load alignment/extension and result mux,
// retired-instruction counter. StallW holds everything; FlushW clears ValidW even while stalled.
module writeback_stage #(
    parameter int XLEN  = 64,
    parameter int RA_W  = 5,
    parameter int CNT_W = 64
) (
    input logic              clk,
    input logic              rst,
    writeback_stage_if.slave wb
);
    localparam int OFF_W = $clog2(XLEN / 8);

    logic             valid_q,     valid_d;
    logic             regwrite_q,  regwrite_d;
    logic [1:0]       resultsrc_q, resultsrc_d;
    logic [2:0]       funct3_q,    funct3_d;
    logic [RA_W-1:0]  rd_q,        rd_d;
    logic [XLEN-1:0]  alu_q,       alu_d;
    logic [XLEN-1:0]  rdata_q,     rdata_d;
    logic [XLEN-1:0]  pc4_q,       pc4_d;
    logic [CNT_W-1:0] instret_q,   instret_d;

    always_comb begin
        regwrite_d  = regwrite_q;
        resultsrc_d = resultsrc_q;
        funct3_d    = funct3_q;
        rd_d        = rd_q;
        alu_d       = alu_q;
        rdata_d     = rdata_q;
        pc4_d       = pc4_q;
        instret_d   = instret_q;
        valid_d     = valid_q & ~wb.FlushW;
        if (!wb.StallW) begin
            valid_d     = wb.ValidM & ~wb.FlushW;
            regwrite_d  = wb.RegWriteM;
            resultsrc_d = wb.ResultSrcM;
            funct3_d    = wb.Funct3M;
            rd_d        = wb.RdM;
            alu_d       = wb.ALU_ResultM;
            rdata_d     = wb.ReadDataM;
            pc4_d       = wb.PCPlus4M;
            // the instruction currently in W leaves on this edge
            instret_d   = instret_q + CNT_W'(valid_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= 1'b0;
            regwrite_q  <= 1'b0;
            resultsrc_q <= '0;
            funct3_q    <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            instret_q   <= '0;
        end else begin
            valid_q     <= valid_d;
            regwrite_q  <= regwrite_d;
            resultsrc_q <= resultsrc_d;
            funct3_q    <= funct3_d;
            rd_q        <= rd_d;
            alu_q       <= alu_d;
            rdata_q     <= rdata_d;
            pc4_q       <= pc4_d;
            instret_q   <= instret_d;
        end
    end

    logic [1:0]       size;
    logic [OFF_W-1:0] lane_off;
    logic [XLEN-1:0]  shifted;
    logic [XLEN-1:0]  load_val;

    always_comb begin
        size = funct3_q[1:0];
        // a 32-bit datapath has no doubleword: LD/LWU/111 collapse to a full-word load
        if (XLEN == 32 && size == 2'b11) begin
            size = 2'b10;
        end
        lane_off = alu_q[OFF_W-1:0] & ~OFF_W'((1 << size) - 1);
        shifted  = rdata_q >> {lane_off, 3'b000};
        case (size)
            2'b00:   load_val = funct3_q[2] ? XLEN'(shifted[7:0])
                                            : XLEN'($signed(shifted[7:0]));
            2'b01:   load_val = funct3_q[2] ? XLEN'(shifted[15:0])
                                            : XLEN'($signed(shifted[15:0]));
            2'b10:   load_val = funct3_q[2] ? XLEN'(shifted[31:0])
                                            : XLEN'($signed(shifted[31:0]));
            default: load_val = shifted;
        endcase
    end

    always_comb begin
        case (resultsrc_q)
            2'b01:   wb.ResultW = load_val;
            2'b10:   wb.ResultW = pc4_q;
            default: wb.ResultW = alu_q;
        endcase
    end

    assign wb.RdW       = rd_q;
    assign wb.ValidW    = valid_q;
    assign wb.RegWriteW = valid_q & regwrite_q & (rd_q != '0);
    assign wb.InstRetW  = instret_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: a 64-bit instance with a 4-bit retire counter and a 32-bit
// instance with the default counter, both fed the same instruction stream.
module tb_writeback_stage;
    logic clk;
    logic rst;

    writeback_stage_if #(.XLEN(64), .RA_W(5), .CNT_W(4))  bus64 ();
    writeback_stage_if #(.XLEN(32), .RA_W(5), .CNT_W(64)) bus32 ();

    writeback_stage #(.XLEN(64), .RA_W(5), .CNT_W(4)) dut64 (
        .clk (clk),
        .rst (rst),
        .wb  (bus64)
    );

    writeback_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut32 (
        .clk (clk),
        .rst (rst),
        .wb  (bus32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic        rw;
        logic [4:0]  rd;
        logic [63:0] r64;
        logic [63:0] r32;
        logic        chk;
        logic [63:0] cnt;
    } exp_t;

    exp_t cur;
    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] load_model(input int xlen, input logic [2:0] f3,
                                               input logic [63:0] addr, input logic [63:0] data);
        int          sz;
        int          off;
        int          nb;
        logic [63:0] w;
        logic [63:0] d;
        case (f3[1:0])
            2'd0:    sz = 1;
            2'd1:    sz = 2;
            2'd2:    sz = 4;
            default: sz = 8;
        endcase
        if (xlen == 32 && sz == 8) sz = 4;
        d = (xlen == 32) ? (data & 64'hFFFF_FFFF) : data;
        off = int'(addr % 64'(xlen / 8));
        off = off - (off % sz);
        w = d >> (8 * off);
        nb = 8 * sz;
        if (nb < 64) begin
            w = w & ((64'd1 << nb) - 64'd1);
            if (!f3[2] && w[nb-1] && nb < xlen) w = w | ~((64'd1 << nb) - 64'd1);
        end
        if (xlen == 32) w = w & 64'hFFFF_FFFF;
        return w;
    endfunction

    function automatic logic [63:0] result_model(input int xlen, input logic [1:0] src,
                                                 input logic [2:0] f3, input logic [63:0] alu,
                                                 input logic [63:0] data, input logic [63:0] pc4);
        logic [63:0] m;
        m = (xlen == 32) ? 64'hFFFF_FFFF : '1;
        if (src == 2'b01) return load_model(xlen, f3, alu, data);
        if (src == 2'b10) return pc4 & m;
        return alu & m;
    endfunction

    task automatic compare(input exp_t e, input string tag);
        check({tag, " ValidW64"},    64'(bus64.ValidW),    64'(e.valid));
        check({tag, " ValidW32"},    64'(bus32.ValidW),    64'(e.valid));
        check({tag, " RegWriteW64"}, 64'(bus64.RegWriteW), 64'(e.valid & e.rw & (e.rd != 0)));
        check({tag, " RegWriteW32"}, 64'(bus32.RegWriteW), 64'(e.valid & e.rw & (e.rd != 0)));
        check({tag, " InstRetW64"},  64'(bus64.InstRetW),  64'(e.cnt[3:0]));
        check({tag, " InstRetW32"},  bus32.InstRetW,       e.cnt);
        if (e.chk) begin
            check({tag, " RdW64"},     64'(bus64.RdW),     64'(e.rd));
            check({tag, " RdW32"},     64'(bus32.RdW),     64'(e.rd));
            check({tag, " ResultW64"}, bus64.ResultW,      e.r64);
            check({tag, " ResultW32"}, 64'(bus32.ResultW), e.r32);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t z;
        z.valid = 1'b0; z.rw = 1'b0; z.rd = '0;
        z.r64 = '0; z.r32 = '0; z.chk = 1'b1; z.cnt = '0;
        return z;
    endfunction

    task automatic step(input string tag, input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [63:0] alu,
                        input logic [63:0] data, input logic [63:0] pc4,
                        input logic stall, input logic flush);
        exp_t nxt;
        exp_t got;
        bus64.ValidM = v;  bus64.RegWriteM = rw; bus64.ResultSrcM = src; bus64.Funct3M = f3;
        bus64.RdM = rd;    bus64.ALU_ResultM = alu; bus64.ReadDataM = data; bus64.PCPlus4M = pc4;
        bus64.StallW = stall; bus64.FlushW = flush;
        bus32.ValidM = v;  bus32.RegWriteM = rw; bus32.ResultSrcM = src; bus32.Funct3M = f3;
        bus32.RdM = rd;    bus32.ALU_ResultM = alu[31:0]; bus32.ReadDataM = data[31:0];
        bus32.PCPlus4M = pc4[31:0];
        bus32.StallW = stall; bus32.FlushW = flush;
        nxt = cur;
        if (stall) begin
            if (flush) nxt.valid = 1'b0;
        end else begin
            nxt.cnt   = cur.cnt + 64'(cur.valid);
            nxt.valid = v & ~flush;
            nxt.rw    = rw;
            nxt.rd    = rd;
            nxt.r64   = result_model(64, src, f3, alu, data, pc4);
            nxt.r32   = result_model(32, src, f3, alu & 64'hFFFF_FFFF,
                                     data & 64'hFFFF_FFFF, pc4 & 64'hFFFF_FFFF);
            nxt.chk   = ~flush;
        end
        sb.push_back(nxt);
        cur = nxt;
        @(posedge clk);
        #1;
        got = sb.pop_front();
        compare(got, tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    endtask

    localparam logic [63:0] LDATA = 64'h8877_6655_4433_2211;
    localparam logic [63:0] LADDR = 64'h0000_0000_0000_1006;

    initial begin
        rst = 1'b1;
        step("pre", 1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
        // clock edges while in reset must not capture; expected state is the reset state
        cur = zero_exp();
        compare(cur, "reset");
        rst = 1'b0;

        step("alu_rd5", 1'b1, 1'b1, 2'b00, 3'b000, 5'd5, 64'h1234, 64'd0, 64'd0, 1'b0, 1'b0);
        check("alu_rd5 literal", bus64.ResultW, 64'h1234);
        idle("retire1");
        check("retire1 literal", 64'(bus64.InstRetW), 64'd1);

        step("LB",  1'b1, 1'b1, 2'b01, 3'b000, 5'd7, LADDR, LDATA, 64'd0, 1'b0, 1'b0);
        check("LB literal", bus64.ResultW, 64'h0000_0000_0000_0077);
        step("LH",  1'b1, 1'b1, 2'b01, 3'b001, 5'd8, LADDR, LDATA, 64'd0, 1'b0, 1'b0);
        check("LH literal", bus64.ResultW, 64'hFFFF_FFFF_FFFF_8877);
        step("LWU", 1'b1, 1'b1, 2'b01, 3'b110, 5'd9, LADDR, LDATA, 64'd0, 1'b0, 1'b0);
        check("LWU literal", bus64.ResultW, 64'h0000_0000_8877_6655);
        step("LD",  1'b1, 1'b1, 2'b01, 3'b011, 5'd10, LADDR, LDATA, 64'd0, 1'b0, 1'b0);
        check("LD literal", bus64.ResultW, LDATA);
        check("LD32 literal", 64'(bus32.ResultW), 64'h4433_2211);
        step("LW",  1'b1, 1'b1, 2'b01, 3'b010, 5'd11, LADDR, LDATA, 64'd0, 1'b0, 1'b0);
        step("LBU", 1'b1, 1'b1, 2'b01, 3'b100, 5'd12, 64'd5, LDATA, 64'd0, 1'b0, 1'b0);
        step("LHU", 1'b1, 1'b1, 2'b01, 3'b101, 5'd13, 64'd7, LDATA, 64'd0, 1'b0, 1'b0);
        step("F111", 1'b1, 1'b1, 2'b01, 3'b111, 5'd14, 64'd3, LDATA, 64'd0, 1'b0, 1'b0);
        step("src11", 1'b1, 1'b1, 2'b11, 3'b000, 5'd15, 64'hDEAD_BEEF_0BAD_F00D, LDATA,
             64'd4, 1'b0, 1'b0);

        step("pc4_x0", 1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 64'd0, 64'd0, 64'h8000_0004, 1'b0, 1'b0);
        check("pc4_x0 literal", bus64.ResultW, 64'h0000_0000_8000_0004);
        idle("pc4_retire");

        step("pre_stall", 1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 64'hCAFE, 64'd0, 64'd0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step("stall", 1'b1, 1'b1, 2'b10, 3'b000, 5'(20 + i), 64'(i), 64'd0,
                 64'h1111 * 64'(i + 1), 1'b1, 1'b0);
        end
        step("stall_flush", 1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 64'h77, 64'd0, 64'd0, 1'b1, 1'b1);
        step("flush", 1'b1, 1'b1, 2'b00, 3'b000, 5'd4, 64'h77, 64'd0, 64'd0, 1'b0, 1'b1);
        idle("post_flush");

        for (int i = 0; i < 40; i++) begin
            step("rand", 1'b1, 1'($urandom), 2'($urandom_range(0, 3)), 3'($urandom),
                 5'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
        end

        step("pre_arst", 1'b1, 1'b1, 2'b00, 3'b000, 5'd6, 64'h55AA, 64'd0, 64'd0, 1'b0, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        cur = zero_exp();
        compare(cur, "arst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("post_arst", 1'b1, 1'b1, 2'b00, 3'b000, 5'd2, 64'hABCD, 64'd0, 64'd0, 1'b0, 1'b0);
        idle("post_arst_retire");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
